real_settle_monitor: RTL and testbench

Synthesizable measurement block on the consuming end of a fixed-point real signal, such as a filter's `v_out`. After a start pulse it watches the signal and reports three results: the settling time in cycles, whether the signal settled or timed out, and the signed peak value. It sits in emulation testbenches beside the probe of the model output, so step-response checks run in hardware rather than by post-processing probe dumps.

---
 rtl/real_monitor_pkg.sv | 20 ++
 rtl/band_cmp.sv | 25 ++
 rtl/real_settle_monitor.sv | 135 +++++++++++++
 tb/tb_real_settle_monitor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/real_monitor_pkg.sv
// Shared types and elaboration-time helpers for the real-signal measurement monitors.
package real_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    DONE
  } monitor_state_t;

  // Width of a counter that must hold every value from 0 to max_count inclusive.
  function automatic int count_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  // Two's-complement most negative value of the given width, in the low bits.
  function automatic logic [63:0] most_negative(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/band_cmp.sv
// Combinational tolerance-band test: in_band = |v_in - TARGET| <= TOL, inclusive.
module band_cmp #(
  parameter int WIDTH  = 18,
  parameter int TARGET = 16384,
  parameter int TOL    = 164
) (
  input  logic signed [WIDTH-1:0] v_in,
  output logic                    in_band
);

  // Two guard bits keep the difference and its magnitude exact at both rails.
  localparam int XW = WIDTH + 2;
  localparam logic signed [XW-1:0] TARGET_X = XW'(TARGET);
  localparam logic signed [XW-1:0] TOL_X    = XW'(TOL);

  logic signed [XW-1:0] diff;
  logic signed [XW-1:0] mag;

  always_comb begin
    diff    = $signed({{2{v_in[WIDTH-1]}}, v_in}) - TARGET_X;
    mag     = diff[XW-1] ? -diff : diff;
    in_band = (mag <= TOL_X);
  end

endmodule

// File: rtl/real_settle_monitor.sv
// Step-response monitor: after start, reports settling index, settle/timeout flag and
// signed peak of a fixed-point real signal.
module real_settle_monitor
  import real_monitor_pkg::*;
#(
  parameter int  WIDTH      = 18,
  parameter int  EXPONENT   = -14,
  parameter int  TARGET     = 16384,
  parameter int  TOL        = 164,
  parameter int  HOLD       = 4,
  parameter int  MAX_CYCLES = 1000,
  localparam int CW         = count_width(MAX_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] v_in,
  output logic                    busy,
  output logic                    done,
  output logic                    settled,
  output logic [CW-1:0]           settle_cycles,
  output logic signed [WIDTH-1:0] peak
);

  localparam int RW = $clog2(HOLD + 1);
  localparam logic [63:0] PEAK_MIN_64 = most_negative(WIDTH);
  localparam logic signed [WIDTH-1:0] PEAK_MIN = PEAK_MIN_64[WIDTH-1:0];

  // The exponent only scales interpretation; values out of this range are not supported.
  if (EXPONENT < -64 || EXPONENT > 64 || HOLD < 1 || MAX_CYCLES < 1 || TOL < 0) begin : g_param_range
  end

  monitor_state_t                state_reg, state_next;
  logic [CW-1:0]                 n_reg, n_next;
  logic [RW-1:0]                 run_reg, run_next, run_sat;
  logic [CW-1:0]                 entry_reg, entry_next;
  logic                          busy_reg, busy_next;
  logic                          done_reg, done_next;
  logic                          settled_reg, settled_next;
  logic [CW-1:0]                 cycles_reg, cycles_next;
  logic signed [WIDTH-1:0]       peak_reg, peak_next;
  logic                          in_band;

  band_cmp #(
    .WIDTH  (WIDTH),
    .TARGET (TARGET),
    .TOL    (TOL)
  ) u_band (
    .v_in    (v_in),
    .in_band (in_band)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      n_reg       <= '0;
      run_reg     <= '0;
      entry_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      settled_reg <= 1'b0;
      cycles_reg  <= '0;
      peak_reg    <= PEAK_MIN;
    end else begin
      state_reg   <= state_next;
      n_reg       <= n_next;
      run_reg     <= run_next;
      entry_reg   <= entry_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      settled_reg <= settled_next;
      cycles_reg  <= cycles_next;
      peak_reg    <= peak_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    n_next       = n_reg;
    run_next     = run_reg;
    entry_next   = entry_reg;
    done_next    = done_reg;
    settled_next = settled_reg;
    cycles_next  = cycles_reg;
    peak_next    = peak_reg;
    run_sat      = (run_reg == RW'(HOLD)) ? run_reg : run_reg + RW'(1);

    if (start) begin
      // Restart from any state; a sample arriving with start is discarded.
      state_next   = TRACK;
      n_next       = '0;
      run_next     = '0;
      entry_next   = '0;
      done_next    = 1'b0;
      settled_next = 1'b0;
      cycles_next  = '0;
      peak_next    = PEAK_MIN;
    end else begin
      case (state_reg)
        TRACK: begin
          n_next = n_reg + CW'(1);
          if (v_in > peak_reg) peak_next = v_in;
          if (in_band) begin
            run_next = run_sat;
            if (run_reg == '0) entry_next = n_reg;
          end else begin
            run_next = '0;
          end
          // Settle is checked first so it wins on the final sample.
          if (in_band && run_sat == RW'(HOLD)) begin
            state_next   = DONE;
            done_next    = 1'b1;
            settled_next = 1'b1;
            cycles_next  = (run_reg == '0) ? n_reg : entry_reg;
          end else if (n_reg == CW'(MAX_CYCLES - 1)) begin
            state_next   = DONE;
            done_next    = 1'b1;
            settled_next = 1'b0;
            cycles_next  = CW'(MAX_CYCLES);
          end
        end
        default: ;
      endcase
    end

    busy_next = (state_next == TRACK);
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign settled       = settled_reg;
  assign settle_cycles = cycles_reg;
  assign peak          = peak_reg;

endmodule

// File: tb/tb_real_settle_monitor.sv
// Directed bench for real_settle_monitor at default parameters.
module tb_real_settle_monitor;

  localparam int WIDTH = 18;
  localparam int CW    = 10;
  localparam int PMIN  = -131072;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic signed [WIDTH-1:0] v_in;
  logic                    busy;
  logic                    done;
  logic                    settled;
  logic [CW-1:0]           settle_cycles;
  logic signed [WIDTH-1:0] peak;

  int total = 0;
  int bad   = 0;
  int cur_v = 0;
  int lat;

  typedef struct {
    int v;
    int settled;
    int cycles;
    int peak;
    int lat;
  } vec_t;

  vec_t vecs[8];

  real_settle_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .v_in          (v_in),
    .busy          (busy),
    .done          (done),
    .settled       (settled),
    .settle_cycles (settle_cycles),
    .peak          (peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pattern(input int mode, input int idx);
    case (mode)
      1: begin
        if (idx < 2) return 0;
        if (idx < 4) return 16400;
        if (idx == 4) return 17000;
        if (idx == 5) return 0;
        return 16384;
      end
      2: return (idx < 2) ? 0 : 16384;
      default: return cur_v;
    endcase
  endfunction

  // Pulse start for one edge; index-0 value is driven right after that edge.
  task automatic pulse_start(input int v0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    v_in  = WIDTH'(v0);
  endtask

  // Counts edges after the start edge until done; -1 if the budget expires.
  task automatic track(input int mode, input int limit, output int latency);
    latency = -1;
    for (int e = 1; e <= limit; e++) begin
      @(negedge clk);
      if (done) begin
        latency = e;
        break;
      end
      v_in = WIDTH'(pattern(mode, e));
    end
  endtask

  task automatic check_result(input string name, input int lat_got, input int lat_exp,
                              input int s_exp, input int c_exp, input int p_exp);
    chk({name, ".latency"}, lat_got, lat_exp);
    chk({name, ".done"}, int'(done), 1);
    chk({name, ".busy"}, int'(busy), 0);
    chk({name, ".settled"}, int'(settled), s_exp);
    chk({name, ".cycles"}, int'(settle_cycles), c_exp);
    chk({name, ".peak"}, int'(peak), p_exp);
    $display("%s: lat=%0d settled=%0d cycles=%0d peak=%0d", name, lat_got, settled,
             settle_cycles, peak);
  endtask

  task automatic check_reset(input string name);
    chk({name, ".busy"}, int'(busy), 0);
    chk({name, ".done"}, int'(done), 0);
    chk({name, ".settled"}, int'(settled), 0);
    chk({name, ".cycles"}, int'(settle_cycles), 0);
    chk({name, ".peak"}, int'(peak), PMIN);
  endtask

  initial begin
    vecs[0] = '{16384,   1, 0,    16384,   4};
    vecs[1] = '{16548,   1, 0,    16548,   4};
    vecs[2] = '{16549,   0, 1000, 16549,   1000};
    vecs[3] = '{0,       0, 1000, 0,       1000};
    vecs[4] = '{-131072, 0, 1000, -131072, 1000};
    vecs[5] = '{16220,   1, 0,    16220,   4};
    vecs[6] = '{16219,   0, 1000, 16219,   1000};
    vecs[7] = '{131071,  0, 1000, 131071,  1000};

    rst   = 1'b0;
    start = 1'b0;
    v_in  = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    $display("reset state checked");
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cur_v = vecs[i].v;
      pulse_start(pattern(0, 0));
      chk("vec.busy_after_start", int'(busy), 1);
      track(0, 1100, lat);
      check_result($sformatf("vec%0d v=%0d", i, vecs[i].v), lat, vecs[i].lat,
                   vecs[i].settled, vecs[i].cycles, vecs[i].peak);
    end

    pulse_start(pattern(1, 0));
    track(1, 1100, lat);
    check_result("profile", lat, 10, 1, 6, 17000);

    // Result must hold while the input wanders.
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      v_in = WIDTH'((c * 7919) % 262144 - 131072);
      chk("hold", int'({done, settled}), 3);
      chk("hold.cycles", int'(settle_cycles), 6);
      chk("hold.peak", int'(peak), 17000);
    end
    $display("done hold: 50 cycles checked");

    @(negedge clk);
    start = 1'b1;
    chk("restart.done_before_edge", int'(done), 1);
    @(negedge clk);
    start = 1'b0;
    v_in  = '0;
    chk("restart.done_cleared", int'(done), 0);
    chk("restart.busy", int'(busy), 1);
    chk("restart.peak", int'(peak), PMIN);
    $display("start in DONE: cleared");

    // Asynchronous reset mid-measurement, then start while held in reset.
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset("async_reset");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("start_in_reset.busy", int'(busy), 0);
    chk("start_in_reset.done", int'(done), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset.busy", int'(busy), 0);
    $display("async reset and start-during-reset checked");

    // Restart at sample 2 of an in-band run.
    pulse_start(16384);
    @(negedge clk);
    pulse_start(pattern(2, 0));
    track(2, 1100, lat);
    check_result("restart_mid_track", lat, 6, 1, 2, 16384);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
